// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one vga_adapter plot port between N pixel
// requesters, with a full-screen background clear sweep.
module vga_plot_arbiter #(
  parameter int unsigned N              = 4,
  parameter logic [2:0]  BG_COLOUR      = 3'b000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_x,
  input  logic [7*N-1:0]   req_y,
  input  logic [3*N-1:0]   req_colour,
  output logic [N-1:0]     req_ready,
  input  logic             clear_req,
  output logic [7:0]       x,
  output logic [6:0]       y,
  output logic [2:0]       colour,
  output logic             writeEn,
  output logic             busy,
  output logic             clear_done,
  output logic             dropped
);

  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;
  localparam int unsigned CW    = 3;
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(159);
  localparam logic [YW-1:0] Y_LAST = YW'(119);
  localparam logic [XW-1:0] X_LIM  = XW'(160);
  localparam logic [YW-1:0] Y_LIM  = YW'(120);

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_nxt;
  logic [XW-1:0]    sx, sx_nxt;
  logic [YW-1:0]    sy, sy_nxt;
  logic [XW-1:0]    x_nxt;
  logic [YW-1:0]    y_nxt;
  logic [CW-1:0]    colour_nxt;
  logic             we_nxt, done_nxt, drop_nxt;

  logic             grant_valid;
  logic [PTR_W-1:0] grant;
  logic [XW-1:0]    sel_x;
  logic [YW-1:0]    sel_y;
  logic [CW-1:0]    sel_colour;
  int unsigned      scan_idx;

  assign busy = (state == CLEAR);

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    scan_idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = (32'(rr_ptr) + k) % N;
      if (!grant_valid && req_valid[PTR_W'(scan_idx)]) begin
        grant_valid = 1'b1;
        grant       = PTR_W'(scan_idx);
      end
    end
  end

  // Granted requester's payload.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == PTR_W'(i)) begin
        sel_x      = req_x[i*XW +: XW];
        sel_y      = req_y[i*YW +: YW];
        sel_colour = req_colour[i*CW +: CW];
      end
    end
  end

  // Next-state, handshake and next-output logic.
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    sx_nxt     = sx;
    sy_nxt     = sy;
    x_nxt      = x;
    y_nxt      = y;
    colour_nxt = colour;
    we_nxt     = 1'b0;
    done_nxt   = 1'b0;
    drop_nxt   = 1'b0;
    req_ready  = '0;

    unique case (state)
      SERVE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          sx_nxt    = '0;
          sy_nxt    = '0;
        end else if (grant_valid) begin
          req_ready[grant] = 1'b1;
          rr_nxt = (grant == PTR_W'(N - 1)) ? '0 : grant + PTR_W'(1);
          // Off-screen pixels are consumed but never reach the port.
          if (sel_x >= X_LIM || sel_y >= Y_LIM) begin
            drop_nxt = 1'b1;
          end else begin
            x_nxt      = sel_x;
            y_nxt      = sel_y;
            colour_nxt = sel_colour;
            we_nxt     = 1'b1;
          end
        end
      end
      CLEAR: begin
        x_nxt      = sx;
        y_nxt      = sy;
        colour_nxt = BG_COLOUR;
        we_nxt     = 1'b1;
        if (sx == X_LAST) begin
          sx_nxt = '0;
          if (sy == Y_LAST) begin
            sy_nxt    = '0;
            state_nxt = SERVE;
            done_nxt  = 1'b1;
          end else begin
            sy_nxt = sy + YW'(1);
          end
        end else begin
          sx_nxt = sx + XW'(1);
        end
      end
      default: state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? CLEAR : SERVE;
      rr_ptr     <= '0;
      sx         <= '0;
      sy         <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      writeEn    <= 1'b0;
      clear_done <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      sx         <= sx_nxt;
      sy         <= sy_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      colour     <= colour_nxt;
      writeEn    <= we_nxt;
      clear_done <= done_nxt;
      dropped    <= drop_nxt;
    end
  end

endmodule
